// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package hilo_pkg;

  localparam int HILO_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

endpackage

// File: rtl/hilo_step_unit.sv
// One combinational iteration: radix-2 shift-add multiply step or restoring divide step.
module hilo_step_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               bit_in,
  input  step_mode_e         mode,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (bit_in ? {1'b0, operand} : '0);
    shifted  = {acc[2*WIDTH-1:WIDTH], bit_in};
    diff     = shifted - {1'b0, operand};
    q_bit    = 1'b0;
    acc_next = acc;
    if (mode == STEP_MUL) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      // Partial remainder is always below the divisor, so diff[WIDTH] is a clean borrow flag.
      // The quotient LSB is left zero here; the caller merges q_bit into it.
      q_bit    = ~diff[WIDTH];
      acc_next = {(q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO owner for the EX stage: iterative mul/div, MTHI/MTLO, and pipeline stall request.
module hilo_muldiv_sequencer
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiLoRead,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic             DivZero
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic               is_div_q, is_div_d;
  logic               div_zero_q, div_zero_d;
  logic               done_q, done_d;
  logic               dz_pulse_q, dz_pulse_d;

  logic               accept;
  logic               op_signed;
  logic               op_div;
  step_mode_e         step_mode;
  logic               step_bit;
  logic [WIDTH-1:0]   step_operand;
  logic [2*WIDTH-1:0] step_acc;
  logic               step_q_bit;

  // Multiply consumes multiplier bits LSB first; divide consumes dividend bits MSB first.
  assign step_mode    = (state_q == DIV) ? STEP_DIV : STEP_MUL;
  assign step_bit     = (state_q == DIV) ? opa_q[WIDTH-1] : opb_q[0];
  assign step_operand = (state_q == DIV) ? opb_q : opa_q;

  hilo_step_unit #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .operand  (step_operand),
    .bit_in   (step_bit),
    .mode     (step_mode),
    .acc_next (step_acc),
    .q_bit    (step_q_bit)
  );

  assign accept    = Start && (state_q == IDLE) && (Op <= OP_MTLO);
  assign op_signed = (Op == OP_MULT) || (Op == OP_DIV);
  assign op_div    = (Op == OP_DIV) || (Op == OP_DIVU);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    is_div_d   = is_div_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;
    dz_pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (Op == OP_MTHI) begin
            hi_d = A;
          end else if (Op == OP_MTLO) begin
            lo_d = A;
          end else begin
            opa_d      = (op_signed && A[WIDTH-1]) ? -A : A;
            opb_d      = (op_signed && B[WIDTH-1]) ? -B : B;
            neg_quot_d = op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_rem_d  = op_signed && A[WIDTH-1];
            acc_d      = '0;
            cnt_d      = '0;
            is_div_d   = op_div;
            div_zero_d = op_div && (B == '0);
            if (!op_div)        state_d = MUL;
            else if (B == '0)   state_d = FIX;
            else                state_d = DIV;
          end
        end
      end
      MUL, DIV: begin
        acc_d = step_acc | {{(2*WIDTH-1){1'b0}}, step_q_bit};
        cnt_d = cnt_q + 1'b1;
        if (state_q == MUL) opb_d = opb_q >> 1;
        else                opa_d = opa_q << 1;
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (div_zero_q) begin
          // Re-negating |A| restores the original signed dividend.
          hi_d       = neg_rem_q ? -opa_q : opa_q;
          lo_d       = '1;
          dz_pulse_d = 1'b1;
        end else if (is_div_q) begin
          lo_d = neg_quot_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = neg_quot_q ? -acc_q : acc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      is_div_q   <= is_div_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
      dz_pulse_q <= dz_pulse_d;
    end
  end

  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign Busy    = (state_q != IDLE);
  assign Stall   = Busy && (Start || HiLoRead);
  assign Done    = done_q;
  assign DivZero = dz_pulse_q;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Directed vector bench for the HI/LO multiply/divide sequencer.
module tb_hilo_muldiv_sequencer;
  import hilo_pkg::*;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Start;
  logic [2:0]   Op;
  logic [W-1:0] A, B;
  logic         HiLoRead;
  logic [W-1:0] Hi, Lo;
  logic         Busy, Stall, Done, DivZero;

  int checks = 0;
  int errors = 0;

  hilo_muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .Op       (Op),
    .A        (A),
    .B        (B),
    .HiLoRead (HiLoRead),
    .Hi       (Hi),
    .Lo       (Lo),
    .Busy     (Busy),
    .Stall    (Stall),
    .Done     (Done),
    .DivZero  (DivZero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_dz;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_op(input vec_t v);
    int           lat;
    bit           moved;
    logic [W-1:0] hi0, lo0;
    hi0   = Hi;
    lo0   = Lo;
    Start = 1'b1;
    Op    = v.op;
    A     = v.a;
    B     = v.b;
    tick();
    Start = 1'b0;
    if (v.op >= OP_MTHI) begin
      check({v.name, " busy"}, 64'(Busy), 64'(0));
      check({v.name, " done"}, 64'(Done), 64'(0));
      check({v.name, " hi"}, 64'(Hi), 64'(v.exp_hi));
      check({v.name, " lo"}, 64'(Lo), 64'(v.exp_lo));
      $display("%-12s a=%h b=%h -> hi=%h lo=%h", v.name, v.a, v.b, Hi, Lo);
    end else begin
      check({v.name, " busy"}, 64'(Busy), 64'(1));
      lat   = 0;
      moved = 1'b0;
      while (!Done && lat < 40) begin
        if (Hi !== hi0 || Lo !== lo0) moved = 1'b1;
        tick();
        lat++;
      end
      check({v.name, " latency"}, 64'(lat), 64'(v.exp_dz ? 1 : W + 1));
      check({v.name, " stable"}, 64'(moved), 64'(0));
      check({v.name, " hi"}, 64'(Hi), 64'(v.exp_hi));
      check({v.name, " lo"}, 64'(Lo), 64'(v.exp_lo));
      check({v.name, " divzero"}, 64'(DivZero), 64'(v.exp_dz));
      check({v.name, " busy_end"}, 64'(Busy), 64'(0));
      $display("%-12s a=%h b=%h -> hi=%h lo=%h dz=%0d lat=%0d", v.name, v.a, v.b, Hi, Lo, DivZero, lat);
      tick();
      check({v.name, " done_clr"}, 64'(Done), 64'(0));
      check({v.name, " dz_clr"}, 64'(DivZero), 64'(0));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stall_bad;
    int n;

    vecs[0]  = '{"mult_7_m3",  OP_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{"multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{"divu_100_7", OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[3]  = '{"div_m7_2",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{"div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{"div_5_0",    OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{"mult_m5_m6", OP_MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 32'd0,        32'd30,       1'b0};
    vecs[7]  = '{"div_7_m2",   OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{"mthi",       OP_MTHI,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{"mtlo",       OP_MTLO,  32'hCAFEBABE, 32'd0,        32'h12345678, 32'hCAFEBABE, 1'b0};
    vecs[10] = '{"divu_x_0",   OP_DIVU,  32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF, 1'b1};
    vecs[11] = '{"div_m9_0",   OP_DIV,   32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF, 1'b1};
    vecs[12] = '{"multu_2p32", OP_MULTU, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0};
    vecs[13] = '{"divu_beef",  OP_DIVU,  32'hDEADBEEF, 32'h00000010, 32'h0000000F, 32'h0DEADBEE, 1'b0};

    Rst = 1'b0; Start = 1'b0; Op = '0; A = '0; B = '0; HiLoRead = 1'b0;
    tick();
    tick();
    check("reset hi", 64'(Hi), 64'(0));
    check("reset lo", 64'(Lo), 64'(0));
    check("reset busy", 64'(Busy), 64'(0));
    check("reset done", 64'(Done), 64'(0));
    check("reset divzero", 64'(DivZero), 64'(0));
    Rst = 1'b1;
    tick();

    foreach (vecs[i]) run_op(vecs[i]);

    // Op 6 is not a HI/LO op: nothing changes.
    Start = 1'b1; Op = 3'd6; A = 32'h55555555; B = 32'd1;
    tick();
    Start = 1'b0;
    check("op6 busy", 64'(Busy), 64'(0));
    check("op6 hi", 64'(Hi), 64'(32'h0DEADBEE ^ 32'h0DEADBEE ^ 32'h0000000F));
    check("op6 lo", 64'(Lo), 64'(32'h0DEADBEE));
    $display("op6_ignored  hi=%h lo=%h busy=%0d", Hi, Lo, Busy);

    // MULT then MFHI and MTHI held in EX while busy.
    Start = 1'b1; Op = OP_MULT; A = 32'd7; B = 32'hFFFFFFFD;
    check("stall accept", 64'(Stall), 64'(0));
    tick();
    Op = OP_MTHI; A = 32'hAAAA5555; HiLoRead = 1'b1;
    stall_bad = 1'b0;
    n = 0;
    while (Busy && n < 40) begin
      if (!Stall) stall_bad = 1'b1;
      tick();
      n++;
    end
    check("stall busy_cycles", 64'(n), 64'(W + 1));
    check("stall each_cycle", 64'(stall_bad), 64'(0));
    check("stall idle", 64'(Stall), 64'(0));
    check("stall prod_hi", 64'(Hi), 64'(32'hFFFFFFFF));
    check("stall prod_lo", 64'(Lo), 64'(32'hFFFFFFEB));
    check("stall done", 64'(Done), 64'(1));
    tick();
    Start = 1'b0; HiLoRead = 1'b0;
    check("mthi after hi", 64'(Hi), 64'(32'hAAAA5555));
    check("mthi after lo", 64'(Lo), 64'(32'hFFFFFFEB));
    check("mthi after busy", 64'(Busy), 64'(0));
    $display("stall_mthi   busy_cycles=%0d hi=%h lo=%h", n, Hi, Lo);

    // Reset in the middle of a divide (counter reached 10).
    Start = 1'b1; Op = OP_DIV; A = 32'd1000; B = 32'd3;
    tick();
    Start = 1'b0;
    repeat (10) tick();
    check("mid busy_before", 64'(Busy), 64'(1));
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    check("midrst busy", 64'(Busy), 64'(0));
    check("midrst hi", 64'(Hi), 64'(0));
    check("midrst lo", 64'(Lo), 64'(0));
    check("midrst done", 64'(Done), 64'(0));
    $display("mid_reset    busy=%0d hi=%h lo=%h done=%0d", Busy, Hi, Lo, Done);
    tick();
    check("postrst done", 64'(Done), 64'(0));
    run_op('{"multu_3_4", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
